// File: rtl/alarm_bank_ctrl.sv
// Multi-channel alarm controller: N programmable alarms with snooze, ring timeout
// and lowest-index priority arbitration against the watch's binary HOUR/MIN.
module alarm_bank_ctrl #(
    parameter int N_ALR    = 4,
    parameter int SNZ_MIN  = 5,
    parameter int RING_MIN = 3,
    parameter int MAX_SNZ  = 3,
    localparam int SW      = (N_ALR > 1) ? $clog2(N_ALR) : 1
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic [6:0]       HOUR,
    input  logic [6:0]       MIN,
    input  logic [SW-1:0]    SEL,
    input  logic             SET_EN,
    input  logic             FIELD,
    input  logic             U,
    input  logic             D,
    input  logic             SW_A,
    input  logic             SW_SNZ,
    input  logic             SW_STOP,
    output logic [6:0]       HOUR_A,
    output logic [6:0]       MIN_A,
    output logic [N_ALR-1:0] ALR_EN,
    output logic             S,
    output logic [SW-1:0]    RING_ID,
    output logic [3:0]       SNZ_CNT
);

    typedef enum logic [1:0] {IDLE, RING, SNOOZE} state_t;

    state_t           state_q, state_d;
    logic [3:0]       timer_q, timer_d;
    logic [SW-1:0]    ring_id_q, ring_id_d;
    logic [3:0]       snz_cnt_q, snz_cnt_d;
    logic [N_ALR-1:0] en_q, en_d;
    logic [6:0]       hr_q [N_ALR];
    logic [6:0]       hr_d [N_ALR];
    logic [6:0]       mn_q [N_ALR];
    logic [6:0]       mn_d [N_ALR];
    logic [6:0]       min_last_q, min_last_d;
    logic [4:0]       btn_last_q, btn_last_d;
    logic [4:0]       btn_pls_q, btn_pls_d;
    logic             s_q, s_d;

    logic             sel_ok;
    logic [6:0]       cur_hr, cur_mn;
    logic             mt;
    logic             any_hit;
    logic [SW-1:0]    winner;
    logic             pls_u, pls_dn, pls_a, pls_snz, pls_stop;

    assign {pls_u, pls_dn, pls_a, pls_snz, pls_stop} = btn_pls_q;
    assign sel_ok = (int'(SEL) < N_ALR);
    assign cur_hr = sel_ok ? hr_q[SEL] : 7'd0;
    assign cur_mn = sel_ok ? mn_q[SEL] : 7'd0;
    assign mt     = (MIN != min_last_q);

    // Scan from the top down so the lowest matching index is the one left standing.
    always_comb begin
        any_hit = 1'b0;
        winner  = '0;
        for (int i = N_ALR - 1; i >= 0; i--) begin
            if (en_q[i] && hr_q[i] == HOUR && mn_q[i] == MIN) begin
                any_hit = 1'b1;
                winner  = SW'(i);
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        timer_d    = timer_q;
        ring_id_d  = ring_id_q;
        snz_cnt_d  = snz_cnt_q;
        en_d       = en_q;
        hr_d       = hr_q;
        mn_d       = mn_q;
        min_last_d = MIN;
        btn_last_d = {U, D, SW_A, SW_SNZ, SW_STOP};
        btn_pls_d  = btn_last_d & ~btn_last_q;
        s_d        = (state_q == RING);

        if (sel_ok) begin
            if (pls_a)
                en_d[SEL] = ~en_q[SEL];
            if (SET_EN && (pls_u ^ pls_dn)) begin
                if (FIELD)
                    hr_d[SEL] = pls_u ? ((cur_hr == 7'd23) ? 7'd0 : cur_hr + 7'd1)
                                      : ((cur_hr == 7'd0) ? 7'd23 : cur_hr - 7'd1);
                else
                    mn_d[SEL] = pls_u ? ((cur_mn == 7'd59) ? 7'd0 : cur_mn + 7'd1)
                                      : ((cur_mn == 7'd0) ? 7'd59 : cur_mn - 7'd1);
            end
        end

        // Disabling the ringing channel cancels the event ahead of any button or tick.
        case (state_q)
            IDLE: begin
                if (mt && any_hit) begin
                    state_d   = RING;
                    ring_id_d = winner;
                    snz_cnt_d = 4'd0;
                    timer_d   = 4'(RING_MIN);
                end
            end
            RING: begin
                if (!en_q[ring_id_q] || pls_stop) begin
                    state_d = IDLE;
                end else if (pls_snz && snz_cnt_q < 4'(MAX_SNZ)) begin
                    state_d   = SNOOZE;
                    timer_d   = 4'(SNZ_MIN);
                    snz_cnt_d = snz_cnt_q + 4'd1;
                end else if (mt) begin
                    timer_d = timer_q - 4'd1;
                    if (timer_q == 4'd1)
                        state_d = IDLE;
                end
            end
            SNOOZE: begin
                if (!en_q[ring_id_q] || pls_stop) begin
                    state_d = IDLE;
                end else if (mt) begin
                    timer_d = timer_q - 4'd1;
                    if (timer_q == 4'd1) begin
                        state_d = RING;
                        timer_d = 4'(RING_MIN);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q    <= IDLE;
            timer_q    <= 4'd0;
            ring_id_q  <= '0;
            snz_cnt_q  <= 4'd0;
            en_q       <= '0;
            min_last_q <= 7'd0;
            btn_last_q <= 5'd0;
            btn_pls_q  <= 5'd0;
            s_q        <= 1'b0;
            for (int i = 0; i < N_ALR; i++) begin
                hr_q[i] <= 7'd0;
                mn_q[i] <= 7'd0;
            end
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            ring_id_q  <= ring_id_d;
            snz_cnt_q  <= snz_cnt_d;
            en_q       <= en_d;
            min_last_q <= min_last_d;
            btn_last_q <= btn_last_d;
            btn_pls_q  <= btn_pls_d;
            s_q        <= s_d;
            for (int i = 0; i < N_ALR; i++) begin
                hr_q[i] <= hr_d[i];
                mn_q[i] <= mn_d[i];
            end
        end
    end

    assign HOUR_A  = cur_hr;
    assign MIN_A   = cur_mn;
    assign ALR_EN  = en_q;
    assign S       = s_q;
    assign RING_ID = ring_id_q;
    assign SNZ_CNT = snz_cnt_q;

endmodule
